// File: rtl/inert_spi_resp.sv
// SPI mode-3 responder that emulates a small inertial sensor: WHO_AM_I, three
// control registers and a latched 16-bit yaw sample, with a data-ready interrupt.
module inert_spi_resp #(
    parameter logic [7:0] WHOAMI = 8'h6A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic [15:0] yaw_in,
    input  logic        smpl_vld
);

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
    } frame_t;

    logic        ss_ff1, ss_s, ss_prev;
    logic        sclk_ff1, sclk_s, sclk_prev;
    logic        mosi_ff1, mosi_s;
    logic [1:0]  warm;
    logic        armed, in_frame;
    logic [4:0]  bit_cnt;
    logic [15:0] rx_shft;
    logic [7:0]  tx_shft;
    logic [7:0]  int1_ctrl, ctrl1_xl, ctrl2_g;
    logic [15:0] yaw_reg;

    frame_t      frm;
    logic [7:0]  cmd_byte;
    logic [7:0]  rd_val;
    logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic        done, wr_en, int_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_ff1    <= 1'b1;
            ss_s      <= 1'b1;
            ss_prev   <= 1'b1;
            sclk_ff1  <= 1'b1;
            sclk_s    <= 1'b1;
            sclk_prev <= 1'b1;
            mosi_ff1  <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            ss_ff1    <= SS_n;
            ss_s      <= ss_ff1;
            ss_prev   <= ss_s;
            sclk_ff1  <= SCLK;
            sclk_s    <= sclk_ff1;
            sclk_prev <= sclk_s;
            mosi_ff1  <= MOSI;
            mosi_s    <= mosi_ff1;
        end
    end

    assign ss_fall   = ss_prev & ~ss_s;
    assign ss_rise   = ~ss_prev & ss_s;
    assign sclk_rise = ~sclk_prev & sclk_s;
    assign sclk_fall = sclk_prev & ~sclk_s;

    // warm[1] marks the first cycle the synchronized select carries a real
    // sample; a select already low at reset release must not open a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm     <= 2'b00;
            armed    <= 1'b0;
            in_frame <= 1'b0;
        end else begin
            warm <= {warm[0], 1'b1};
            if (warm[1] && ss_s)
                armed <= 1'b1;
            if (ss_fall && armed)
                in_frame <= 1'b1;
            else if (ss_rise)
                in_frame <= 1'b0;
        end
    end

    assign frm      = rx_shft;
    assign cmd_byte = {rx_shft[6:0], mosi_s};

    always_comb begin
        rd_val = 8'h00;
        case (cmd_byte[6:0])
            7'h0D:   rd_val = int1_ctrl;
            7'h0F:   rd_val = WHOAMI;
            7'h10:   rd_val = ctrl1_xl;
            7'h11:   rd_val = ctrl2_g;
            7'h26:   rd_val = yaw_reg[7:0];
            7'h27:   rd_val = yaw_reg[15:8];
            default: rd_val = 8'h00;
        endcase
    end

    // The response byte is loaded on the 8th rise so its MSB is on MISO before the 9th.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 5'd0;
            rx_shft <= 16'h0000;
            tx_shft <= 8'h00;
        end else if (ss_fall && armed) begin
            bit_cnt <= 5'd0;
            tx_shft <= 8'h00;
        end else if (in_frame && !ss_s) begin
            if (sclk_rise) begin
                rx_shft <= {rx_shft[14:0], mosi_s};
                if (bit_cnt != 5'd16)
                    bit_cnt <= bit_cnt + 5'd1;
                if (bit_cnt == 5'd7)
                    tx_shft <= cmd_byte[7] ? rd_val : 8'h00;
            end else if (sclk_fall && bit_cnt >= 5'd9 && bit_cnt <= 5'd15) begin
                tx_shft <= {tx_shft[6:0], 1'b0};
            end
        end
    end

    assign done    = ss_rise && in_frame && (bit_cnt == 5'd16);
    assign wr_en   = done && !frm.rw;
    assign int_clr = done && frm.rw && (frm.addr == 7'h27);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int1_ctrl <= 8'h00;
            ctrl1_xl  <= 8'h00;
            ctrl2_g   <= 8'h00;
            yaw_reg   <= 16'h0000;
            INT       <= 1'b0;
        end else begin
            if (wr_en) begin
                case (frm.addr)
                    7'h0D:   int1_ctrl <= frm.data;
                    7'h10:   ctrl1_xl  <= frm.data;
                    7'h11:   ctrl2_g   <= frm.data;
                    default: ;
                endcase
            end
            if (smpl_vld)
                yaw_reg <= yaw_in;
            if (smpl_vld && int1_ctrl[1])
                INT <= 1'b1;
            else if (int_clr)
                INT <= 1'b0;
        end
    end

    assign MISO = ~ss_s & tx_shft[7];

endmodule

// File: tb/tb_inert_spi_resp.sv
// Bench for inert_spi_resp: table of SPI transactions plus hand sequences for
// sample/interrupt races and mid-frame reset; read data checked via a queue.
module tb_inert_spi_resp;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        SS_n, SCLK, MOSI;
    logic        MISO, INT;
    logic [15:0] yaw_in;
    logic        smpl_vld;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [15:0] word;
        int          nbits;
        logic        is_rd;
        logic [7:0]  exp;
        logic        exp_int;
    } vec_t;

    vec_t tbl[$];

    inert_spi_resp #(.WHOAMI(8'h6A)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .INT     (INT),
        .yaw_in  (yaw_in),
        .smpl_vld(smpl_vld)
    );

    always #5 clk = ~clk;

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Initiator in mode 3: change MOSI on fall, sample MISO just before rise.
    task automatic spi_frame(input logic [15:0] w, input int nbits, output logic [7:0] rd);
        rd = 8'h00;
        SS_n = 1'b0;
        clks(HALF);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = w[15-i];
            clks(HALF);
            if (i >= 8)
                rd = {rd[6:0], MISO};
            SCLK = 1'b1;
            clks(HALF);
        end
    endtask

    task automatic spi_end();
        SS_n = 1'b1;
        MOSI = 1'b0;
        clks(HALF);
    endtask

    task automatic spi_wr(input logic [15:0] w, input int nbits);
        logic [7:0] dummy;
        spi_frame(w, nbits, dummy);
        spi_end();
    endtask

    task automatic spi_rd(input logic [15:0] w, input logic [7:0] exp);
        logic [7:0] got, e;
        sb.push_back(exp);
        spi_frame(w, 16, got);
        spi_end();
        e = sb.pop_front();
        check($sformatf("rd_%h", w), {8'h00, got}, {8'h00, e});
    endtask

    task automatic pulse_smpl(input logic [15:0] y);
        yaw_in   = y;
        smpl_vld = 1'b1;
        clks(1);
        smpl_vld = 1'b0;
    endtask

    function automatic vec_t mk(input logic [15:0] w, input int n, input logic r,
                                input logic [7:0] e, input logic ei);
        vec_t v;
        v.word = w; v.nbits = n; v.is_rd = r; v.exp = e; v.exp_int = ei;
        return v;
    endfunction

    initial begin
        logic [7:0] got, e;

        rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
        yaw_in = 16'h0000; smpl_vld = 1'b0;
        clks(3);
        check("rst_miso", {15'h0, MISO}, 16'h0);
        check("rst_int",  {15'h0, INT},  16'h0);
        rst_n = 1'b1;
        clks(4);

        tbl.push_back(mk(16'h8F00, 16, 1'b1, 8'h6A, 1'b0));
        tbl.push_back(mk(16'h0D02, 16, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(16'h8D00, 16, 1'b1, 8'h02, 1'b0));
        tbl.push_back(mk(16'h1047, 16, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(16'h9000, 16, 1'b1, 8'h47, 1'b0));
        tbl.push_back(mk(16'h0F55, 16, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(16'h8F00, 16, 1'b1, 8'h6A, 1'b0));
        tbl.push_back(mk(16'h20FF, 16, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(16'hA000, 16, 1'b1, 8'h00, 1'b0));
        tbl.push_back(mk(16'h1150, 12, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(16'h9100, 16, 1'b1, 8'h00, 1'b0));
        tbl.push_back(mk(16'h1133, 16, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(16'h9100, 16, 1'b1, 8'h33, 1'b0));
        tbl.push_back(mk(16'hA600, 16, 1'b1, 8'h00, 1'b0));

        foreach (tbl[k]) begin
            if (tbl[k].is_rd)
                spi_rd(tbl[k].word, tbl[k].exp);
            else
                spi_wr(tbl[k].word, tbl[k].nbits);
            check($sformatf("int_after_%h", tbl[k].word), {15'h0, INT}, {15'h0, tbl[k].exp_int});
        end

        // Sample raises INT; low-byte read keeps it, high-byte read clears it
        check("int_pre_smpl", {15'h0, INT}, 16'h0);
        pulse_smpl(16'h1234);
        check("int_set", {15'h0, INT}, 16'h1);
        spi_rd(16'hA600, 8'h34);
        check("int_after_lo", {15'h0, INT}, 16'h1);
        spi_rd(16'hA700, 8'h12);
        check("int_after_hi", {15'h0, INT}, 16'h0);

        // Disabling the interrupt does not clear a pending one
        pulse_smpl(16'hBEEF);
        check("int_set2", {15'h0, INT}, 16'h1);
        spi_wr(16'h0D00, 16);
        check("int_keep_dis", {15'h0, INT}, 16'h1);
        spi_rd(16'h8D00, 8'h00);
        spi_wr(16'h0D02, 16);

        // New sample lands on the very clk the high-byte read completes
        sb.push_back(8'hBE);
        spi_frame(16'hA700, 16, got);
        SS_n = 1'b1;
        clks(2);
        pulse_smpl(16'h5678);
        clks(HALF);
        e = sb.pop_front();
        check("rd_race", {8'h00, got}, {8'h00, e});
        check("int_race", {15'h0, INT}, 16'h1);
        spi_rd(16'hA600, 8'h78);
        spi_rd(16'hA700, 8'h56);
        check("int_clr_after_race", {15'h0, INT}, 16'h0);

        // Reset in the middle of a write frame
        pulse_smpl(16'h0101);
        check("int_pre_rst", {15'h0, INT}, 16'h1);
        spi_frame(16'h1060, 10, got);
        rst_n = 1'b0;
        clks(2);
        check("midrst_miso", {15'h0, MISO}, 16'h0);
        check("midrst_int",  {15'h0, INT},  16'h0);
        rst_n = 1'b1;
        clks(3);
        for (int i = 0; i < 6; i++) begin
            SCLK = 1'b0; MOSI = 1'b1; clks(HALF);
            SCLK = 1'b1; clks(HALF);
        end
        spi_end();
        spi_rd(16'h9000, 8'h00);
        spi_rd(16'h8D00, 8'h00);
        spi_rd(16'hA700, 8'h00);
        spi_rd(16'h8F00, 8'h6A);
        pulse_smpl(16'h4321);
        check("int_dis_after_rst", {15'h0, INT}, 16'h0);
        spi_wr(16'h1060, 16);
        spi_rd(16'h9000, 8'h60);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
